// File: rtl/times_table_rd_ctrl.sv
// Round-robin arbiter for two times-table lookup clients driving an AXI4-lite read master.
// Grant to result_valid is 3 cycles minimum; AR/R stalls are waited out, flagging a sticky stall past TIMEOUT.
module times_table_rd_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [2:0]        a0,
  input  logic [2:0]        b0,
  output logic              ack0,
  input  logic              req1,
  input  logic [2:0]        a1,
  input  logic [2:0]        b1,
  output logic              ack1,
  output logic [5:0]        result,
  output logic              result_id,
  output logic              result_valid,
  output logic              err,
  output logic              stall,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [5:0]        result_q, result_d;
  logic              result_id_q, result_id_d;
  logic              result_valid_q, result_valid_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant;

  // Only the product bits of the read word are meaningful.
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata[DATA_W-1:6];

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    id_d           = id_q;
    araddr_d       = araddr_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    result_d       = result_q;
    result_id_d    = result_id_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    stall_d        = stall_q;
    ack0_d         = ack0_q;
    ack1_d         = ack1_q;
    cnt_d          = cnt_q;
    grant          = 1'b0;

    // Watchdog only observes; the AXI transaction always runs to completion.
    if (state_q == ADDR || state_q == DATA) begin
      if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CNT_W'(TIMEOUT - 1)) stall_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant         = (req0 && req1) ? ~last_grant_q : req1;
          id_d          = grant;
          last_grant_d  = grant;
          araddr_d      = '0;
          araddr_d[7:0] = grant ? {a1, b1, 2'b00} : {a0, b0, 2'b00};
          arvalid_d     = 1'b1;
          cnt_d         = '0;
          state_d       = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (m_axi_rvalid && rready_q) begin
          err_d          = (m_axi_rresp != 2'b00);
          result_d       = (m_axi_rresp != 2'b00) ? 6'd0 : m_axi_rdata[5:0];
          rready_d       = 1'b0;
          result_valid_d = 1'b1;
          result_id_d    = id_q;
          ack0_d         = ~id_q;
          ack1_d         = id_q;
          state_d        = DONE;
        end
      end
      DONE: begin
        result_valid_d = 1'b0;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      id_q           <= 1'b0;
      araddr_q       <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      result_q       <= '0;
      result_id_q    <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      stall_q        <= 1'b0;
      busy_q         <= 1'b0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      id_q           <= id_d;
      araddr_q       <= araddr_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      stall_q        <= stall_d;
      busy_q         <= busy_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      cnt_q          <= cnt_d;
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign result        = result_q;
  assign result_id     = result_id_q;
  assign result_valid  = result_valid_q;
  assign err           = err_q;
  assign stall         = stall_q;
  assign busy          = busy_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: doc/times_table_rd_ctrl.md
Name: times_table_rd_ctrl

Overview:
- Two-requester arbiter and AXI4-lite read-channel master that sequences lookups into the 8x8 times-table memory (3-bit a, 3-bit b, 6-bit product; one 32-bit word per entry).
- Accepts (a,b) lookups from two clients, arbitrates round-robin and computes the word address.
- Runs a compliant AR/R handshake and returns the registered product with requester ID and response status.
- Sits between client logic and the block-memory AXI slave; the write channels of that slave are tied off outside this block.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI read-data width (product taken from bits [5:0]).
- TIMEOUT, 64, cycles spent in ADDR+DATA for one transaction before the sticky stall flag sets.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 lookup request; level, held with a0/b0 until ack0.
- a0  in  3  requester 0 multiplicand.
- b0  in  3  requester 0 multiplier.
- ack0  out  1  one-cycle pulse: requester 0 lookup complete.
- req1  in  1  requester 1 lookup request; same rules as req0.
- a1  in  3  requester 1 multiplicand.
- b1  in  3  requester 1 multiplier.
- ack1  out  1  one-cycle pulse: requester 1 lookup complete.
- result  out  6  product of the completed lookup.
- result_id  out  1  requester that owns result.
- result_valid  out  1  one-cycle pulse; result, result_id and err are valid.
- err  out  1  rresp was non-OKAY for this result; qualified by result_valid.
- stall  out  1  sticky: a transaction exceeded TIMEOUT cycles; cleared only by rst.
- busy  out  1  high in any state other than IDLE.
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, last_grant=1 (requester 0 wins first), all outputs 0 (araddr=0, arvalid=0, rready=0, result=0, result_id=0, result_valid=0, err=0, stall=0, busy=0, ack0/ack1=0), timeout counter=0. A reset mid-transaction drops the transaction; no ack is issued.
- Address: araddr = ((a*8)+b)*4, zero-extended to ADDR_W and computed from the latched a,b. Example: a=7, b=7 gives 0xFC.
- State machine, all outputs registered:
  - IDLE: if any req is high, grant per round-robin. With one requester, grant it. With both, grant the one not equal to last_grant.
    - Latch a, b and id; update last_grant; load araddr; assert arvalid; go to ADDR.
  - ADDR: hold arvalid and araddr stable until arready. On arvalid&arready, drop arvalid, assert rready, go to DATA.
  - DATA: rready held high. On rvalid&rready:
    - capture result=rdata[5:0] and err=(rresp!=2'b00);
    - if err, force result=0;
    - drop rready; go to DONE.
  - DONE, one cycle: result_valid=1, result_id=latched id, ack of the owning requester=1; then go to IDLE.
- Latency:
  - req sampled in IDLE at cycle N gives arvalid=1 at N+1.
  - With arready high at N+1 and rvalid at N+2: rready=1 at N+2 and result_valid/ack at N+3.
  - Back-to-back minimum of 4 cycles per lookup.
- Requesters drop req the cycle after ack. A req still high in the IDLE cycle after DONE is treated as a new request.
- Request inputs are ignored outside IDLE. a/b changes after grant have no effect.
- Timeout counter:
  - clears on entry to ADDR and increments in ADDR and DATA;
  - at TIMEOUT it sets stall and saturates.
  - The transaction is never aborted; the AXI protocol is preserved.
- rvalid seen in ADDR (before the AR handshake) is ignored.
- result and err hold their values until the next capture. result_valid is the qualifier.

Test Plan:
- Reset, then req0 with a0=3, b0=5; slave has arready=1 and returns rdata=15 after 1 cycle -> araddr=0x74; result=15, result_id=0, ack0 pulses, err=0; total 3 cycles from req sample to result_valid.
- req0 and req1 both high continuously (a0=2,b0=2; a1=7,b1=7) -> alternating grants 0,1,0,1; araddr 0x48 then 0xFC; results 4 and 49; ack pulses alternate.
- Slave holds arready=0 for 5 cycles -> arvalid and araddr stay stable and unchanged; rready stays 0 until the AR handshake; completion is correct afterwards.
- Slave returns rresp=2'b10 with rdata=0x3F -> result_valid with err=1, result=0; the next clean lookup gives err=0.
- With TIMEOUT=8, slave withholds rvalid for 12 cycles -> stall=1 at cycle 8 and stays set; the lookup still completes correctly; stall clears only on rst.
- Assert rst while in DATA -> all outputs 0 immediately (asynchronous); no ack; a new req0 afterwards completes normally.
